// File: rtl/mod_segment_scheduler.sv
// Segment playback scheduler: steps a sample index through one of two segments
// at a programmable rate, swapping segments immediately (infinite mode) or at
// the end of the current cycle followed by a counted number of loops and a halt.

package mod_segment_scheduler_pkg;

    typedef struct packed {
        logic        REQ_RD_SEGMENT;
        logic [14:0] CYCLE_0;
        logic [14:0] CYCLE_1;
        logic [31:0] FREQ_DIV_0;
        logic [31:0] FREQ_DIV_1;
        logic [31:0] REP;
    } mod_settings_t;

endpackage

module mod_segment_scheduler
    import mod_segment_scheduler_pkg::*;
#(
    parameter logic [31:0] INFINITE_REP = 32'hFFFF_FFFF
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          UPDATE,
    input  mod_settings_t SETTINGS,
    output logic          SEGMENT,
    output logic [14:0]   IDX,
    output logic          IDX_ADV,
    output logic          STOP
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT,
        ST_FINITE,
        ST_HALT
    } state_t;

    state_t        state;
    state_t        state_next;
    mod_settings_t cfg;
    mod_settings_t cfg_next;
    logic          pending_seg;
    logic          pending_seg_next;
    logic [31:0]   div;
    logic [31:0]   div_next;
    logic [31:0]   loop_cnt;
    logic [31:0]   loop_next;
    logic          segment_next;
    logic [14:0]   idx_next;
    logic          idx_adv_next;
    logic          stop_next;

    logic [14:0]   cur_cycle;
    logic [31:0]   cur_freq;
    logic [31:0]   cur_div_last;
    logic          terminal;
    logic          wrap;

    // Active segment parameters and the divider terminal / cycle wrap events.
    // Comparisons use >= so that shrinking a parameter below the live counter
    // value makes the counter wrap at its next step instead of running away.
    always_comb begin
        cur_cycle    = SEGMENT ? cfg.CYCLE_1 : cfg.CYCLE_0;
        cur_freq     = SEGMENT ? cfg.FREQ_DIV_1 : cfg.FREQ_DIV_0;
        cur_div_last = (cur_freq == 32'd0) ? 32'd0 : cur_freq - 32'd1;
        terminal     = (state != ST_HALT) && (div >= cur_div_last);
        wrap         = terminal && (IDX >= cur_cycle);
    end

    // Next-state logic: the divider/wrap event is evaluated first with the
    // settings currently held, then an UPDATE overrides whatever it touches.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves a variable unassigned, which would otherwise infer a latch.
        state_next       = state;
        cfg_next         = cfg;
        pending_seg_next = pending_seg;
        segment_next     = SEGMENT;
        idx_next         = IDX;
        div_next         = div;
        loop_next        = loop_cnt;
        idx_adv_next     = 1'b0;
        stop_next        = STOP;

        case (state)
            ST_RUN, ST_WAIT, ST_FINITE: begin
                if (!terminal) begin
                    div_next = div + 32'd1;
                end else begin
                    div_next = 32'd0;
                    if (!wrap) begin
                        idx_next     = IDX + 15'd1;
                        idx_adv_next = 1'b1;
                    end else if (state == ST_WAIT) begin
                        // Pending swap lands on the cycle boundary of the
                        // outgoing segment; the new segment starts counting loops.
                        segment_next = pending_seg;
                        idx_next     = 15'd0;
                        loop_next    = 32'd0;
                        idx_adv_next = 1'b1;
                        state_next   = ST_FINITE;
                    end else if ((state == ST_FINITE) && (loop_cnt == cfg.REP)) begin
                        // Last repetition done: freeze on the final sample.
                        div_next   = div;
                        stop_next  = 1'b1;
                        state_next = ST_HALT;
                    end else begin
                        idx_next     = 15'd0;
                        idx_adv_next = 1'b1;
                        if ((state == ST_FINITE) && (loop_cnt != 32'hFFFF_FFFF)) begin
                            loop_next = loop_cnt + 32'd1;
                        end
                    end
                end
            end
            default: begin
                // Halted: counters frozen until an UPDATE arrives.
            end
        endcase

        if (UPDATE) begin
            cfg_next = SETTINGS;
            if (SETTINGS.REQ_RD_SEGMENT != SEGMENT) begin
                if (SETTINGS.REP == INFINITE_REP) begin
                    segment_next = SETTINGS.REQ_RD_SEGMENT;
                    idx_next     = 15'd0;
                    div_next     = 32'd0;
                    loop_next    = 32'd0;
                    idx_adv_next = 1'b0;
                    stop_next    = 1'b0;
                    state_next   = ST_RUN;
                end else begin
                    // Finite request: keep playing the current segment to its
                    // wrap, then swap; leaving HALT resumes counting for that.
                    pending_seg_next = SETTINGS.REQ_RD_SEGMENT;
                    stop_next        = 1'b0;
                    state_next       = ST_WAIT;
                end
            end else if (SETTINGS.REP == INFINITE_REP) begin
                stop_next  = 1'b0;
                state_next = ST_RUN;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!RESET_N) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and output registers; reset also discards any pending swap.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            cfg         <= '0;
            pending_seg <= 1'b0;
            div         <= 32'd0;
            loop_cnt    <= 32'd0;
            SEGMENT     <= 1'b0;
            IDX         <= 15'd0;
            IDX_ADV     <= 1'b0;
            STOP        <= 1'b0;
        end else begin
            cfg         <= cfg_next;
            pending_seg <= pending_seg_next;
            div         <= div_next;
            loop_cnt    <= loop_next;
            SEGMENT     <= segment_next;
            IDX         <= idx_next;
            IDX_ADV     <= idx_adv_next;
            STOP        <= stop_next;
        end
    end

endmodule

// File: tb/tb_mod_segment_scheduler.sv
// Directed bench for mod_segment_scheduler: reset, free-run defaults, divided
// indexing, immediate swap, finite swap with loop count and halt, resume from
// halt, reset during a pending swap, and updates coincident with a wrap.

module tb_mod_segment_scheduler;
    import mod_segment_scheduler_pkg::*;

    localparam logic [31:0] INF = 32'hFFFF_FFFF;

    logic          CLK;
    logic          RESET_N;
    logic          UPDATE;
    mod_settings_t SETTINGS;
    logic          SEGMENT;
    logic [14:0]   IDX;
    logic          IDX_ADV;
    logic          STOP;

    int checks = 0;
    int errors = 0;

    int run_idx[8] = '{0, 1, 1, 2, 2, 3, 3, 0};
    int run_adv[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    int fin_idx[5] = '{0, 1, 0, 1, 1};
    int fin_adv[5] = '{1, 1, 1, 1, 0};
    int fin_stp[5] = '{0, 0, 0, 0, 1};

    mod_segment_scheduler #(
        .INFINITE_REP(INF)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .UPDATE  (UPDATE),
        .SETTINGS(SETTINGS),
        .SEGMENT (SEGMENT),
        .IDX     (IDX),
        .IDX_ADV (IDX_ADV),
        .STOP    (STOP)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One clock edge, then settle before inputs change or outputs are sampled.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic mod_settings_t mk(input logic seg, input logic [14:0] c0, input logic [14:0] c1,
                                         input logic [31:0] fd0, input logic [31:0] fd1, input logic [31:0] rep);
        mod_settings_t s;
        s.REQ_RD_SEGMENT = seg;
        s.CYCLE_0        = c0;
        s.CYCLE_1        = c1;
        s.FREQ_DIV_0     = fd0;
        s.FREQ_DIV_1     = fd1;
        s.REP            = rep;
        return s;
    endfunction

    task automatic pulse_update(input mod_settings_t s);
        UPDATE   = 1'b1;
        SETTINGS = s;
        step();
        UPDATE   = 1'b0;
    endtask

    initial begin
        RESET_N  = 1'b0;
        UPDATE   = 1'b0;
        SETTINGS = '0;
        step();
        step();
        check("rst_segment", 32'(SEGMENT), 32'd0);
        check("rst_idx", 32'(IDX), 32'd0);
        check("rst_idx_adv", 32'(IDX_ADV), 32'd0);
        check("rst_stop", 32'(STOP), 32'd0);

        // Default settings: divider of 1, single-sample cycle.
        RESET_N = 1'b1;
        step();
        check("dflt_adv_a", 32'(IDX_ADV), 32'd1);
        check("dflt_idx_a", 32'(IDX), 32'd0);
        step();
        check("dflt_adv_b", 32'(IDX_ADV), 32'd1);
        check("dflt_idx_b", 32'(IDX), 32'd0);

        // Segment 0, four samples, divide by two, infinite.
        pulse_update(mk(1'b0, 15'd3, 15'd1, 32'd2, 32'd1, INF));
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("run_idx[%0d]", i), 32'(IDX), 32'(run_idx[i]));
            check($sformatf("run_adv[%0d]", i), 32'(IDX_ADV), 32'(run_adv[i]));
        end
        step();
        step();
        step();
        step();
        check("run_at_idx2", 32'(IDX), 32'd2);

        // Immediate swap to segment 1 (divide by three) from IDX=2.
        pulse_update(mk(1'b1, 15'd3, 15'd1, 32'd2, 32'd3, INF));
        check("swap_segment", 32'(SEGMENT), 32'd1);
        check("swap_idx", 32'(IDX), 32'd0);
        check("swap_adv", 32'(IDX_ADV), 32'd0);
        step();
        step();
        check("swap_div_idx", 32'(IDX), 32'd0);
        check("swap_div_adv", 32'(IDX_ADV), 32'd0);
        step();
        check("swap_first_idx", 32'(IDX), 32'd1);
        check("swap_first_adv", 32'(IDX_ADV), 32'd1);

        // Back to segment 0, then request a finite swap at IDX=1.
        pulse_update(mk(1'b0, 15'd3, 15'd1, 32'd2, 32'd1, INF));
        check("back_segment", 32'(SEGMENT), 32'd0);
        check("back_idx", 32'(IDX), 32'd0);
        step();
        step();
        check("pre_wait_idx", 32'(IDX), 32'd1);
        check("pre_wait_adv", 32'(IDX_ADV), 32'd1);
        pulse_update(mk(1'b1, 15'd3, 15'd1, 32'd2, 32'd1, 32'd1));
        check("wait_segment", 32'(SEGMENT), 32'd0);
        check("wait_idx", 32'(IDX), 32'd1);
        check("wait_stop", 32'(STOP), 32'd0);
        step();
        step();
        step();
        step();
        check("wait_last_seg", 32'(SEGMENT), 32'd0);
        check("wait_last_idx", 32'(IDX), 32'd3);
        check("wait_last_adv", 32'(IDX_ADV), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("fin_seg[%0d]", i), 32'(SEGMENT), 32'd1);
            check($sformatf("fin_idx[%0d]", i), 32'(IDX), 32'(fin_idx[i]));
            check($sformatf("fin_adv[%0d]", i), 32'(IDX_ADV), 32'(fin_adv[i]));
            check($sformatf("fin_stop[%0d]", i), 32'(STOP), 32'(fin_stp[i]));
        end
        step();
        step();
        check("halt_idx", 32'(IDX), 32'd1);
        check("halt_stop", 32'(STOP), 32'd1);
        check("halt_adv", 32'(IDX_ADV), 32'd0);

        // Leave HALT with an infinite request for segment 0.
        pulse_update(mk(1'b0, 15'd3, 15'd1, 32'd2, 32'd1, INF));
        check("resume_segment", 32'(SEGMENT), 32'd0);
        check("resume_idx", 32'(IDX), 32'd0);
        check("resume_stop", 32'(STOP), 32'd0);
        check("resume_adv", 32'(IDX_ADV), 32'd0);
        step();
        step();
        check("resume_run_idx", 32'(IDX), 32'd1);
        check("resume_run_adv", 32'(IDX_ADV), 32'd1);

        // Enter WAIT, then reset with a competing UPDATE in the same cycle.
        pulse_update(mk(1'b1, 15'd3, 15'd1, 32'd2, 32'd1, 32'd0));
        check("wait2_idx", 32'(IDX), 32'd1);
        RESET_N  = 1'b0;
        UPDATE   = 1'b1;
        SETTINGS = mk(1'b1, 15'd3, 15'd1, 32'd2, 32'd1, INF);
        step();
        RESET_N = 1'b1;
        UPDATE  = 1'b0;
        check("mid_rst_segment", 32'(SEGMENT), 32'd0);
        check("mid_rst_idx", 32'(IDX), 32'd0);
        check("mid_rst_adv", 32'(IDX_ADV), 32'd0);
        check("mid_rst_stop", 32'(STOP), 32'd0);
        step();
        check("post_rst_seg_a", 32'(SEGMENT), 32'd0);
        check("post_rst_adv_a", 32'(IDX_ADV), 32'd1);
        repeat (5) step();
        check("post_rst_seg_b", 32'(SEGMENT), 32'd0);
        check("post_rst_idx_b", 32'(IDX), 32'd0);
        check("post_rst_adv_b", 32'(IDX_ADV), 32'd1);

        // Divider change landing exactly on a wrap.
        pulse_update(mk(1'b0, 15'd1, 15'd0, 32'd2, 32'd0, INF));
        step();
        step();
        step();
        check("pre_wrap_idx", 32'(IDX), 32'd1);
        check("pre_wrap_adv", 32'(IDX_ADV), 32'd0);
        pulse_update(mk(1'b0, 15'd1, 15'd0, 32'd4, 32'd0, INF));
        check("wrap_upd_idx", 32'(IDX), 32'd0);
        check("wrap_upd_adv", 32'(IDX_ADV), 32'd1);
        step();
        step();
        step();
        check("newdiv_idx", 32'(IDX), 32'd0);
        check("newdiv_adv", 32'(IDX_ADV), 32'd0);
        step();
        check("newdiv_tick_idx", 32'(IDX), 32'd1);
        check("newdiv_tick_adv", 32'(IDX_ADV), 32'd1);

        // Same-segment shrink below the live IDX: held, then wraps to 0.
        pulse_update(mk(1'b0, 15'd0, 15'd0, 32'd4, 32'd0, INF));
        step();
        step();
        check("shrink_hold_idx", 32'(IDX), 32'd1);
        check("shrink_hold_adv", 32'(IDX_ADV), 32'd0);
        step();
        check("shrink_wrap_idx", 32'(IDX), 32'd0);
        check("shrink_wrap_adv", 32'(IDX_ADV), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_segment_scheduler.md
MOD_SEGMENT_SCHEDULER -- requirements
Module: mod_segment_scheduler

Interface
REQ-001 Parameter INFINITE_REP, default 32'hFFFF_FFFF, REP value meaning "loop forever, swap immediately".
REQ-002 CLK  input  1  system clock; all logic is on the rising edge.
REQ-003 RESET_N  input  1  reset, synchronous, active-low.
REQ-004 UPDATE  input  1  single-cycle pulse; new settings valid on SETTINGS.
REQ-005 SETTINGS  input  mod_settings_t  REQ_RD_SEGMENT, CYCLE_0/1 (15b), FREQ_DIV_0/1 (32b), REP (32b).
REQ-006 SEGMENT  output  1  segment currently being read.
REQ-007 IDX  output  15  sample index within SEGMENT.
REQ-008 IDX_ADV  output  1  one-cycle pulse, asserted in the cycle IDX changes.
REQ-009 STOP  output  1  high while playback is frozen after finite repetition.

Function
REQ-010 Settings shall be latched only in a cycle with UPDATE=1; SETTINGS is ignored at all other times.
REQ-011 Cycle length of segment s shall be CYCLE_s+1 samples; IDX range is 0..CYCLE_s.
REQ-012 Divider counter DIV (32b) counts 0..FREQ_DIV_s-1 of the active segment; FREQ_DIV_s=0 is treated as 1.
REQ-013 When DIV=FREQ_DIV_s-1: DIV<=0, IDX_ADV=1, IDX<=IDX+1, or 0 if IDX=CYCLE_s (wrap).
REQ-014 States: RUN (infinite loop), WAIT (swap pending, finite), FINITE (counting loops), HALT.
REQ-015 RUN: UPDATE with REP=INFINITE_REP and REQ_RD_SEGMENT!=SEGMENT -> next cycle SEGMENT<=REQ, IDX<=0, DIV<=0, no IDX_ADV; stay RUN.
REQ-016 RUN: UPDATE with REQ_RD_SEGMENT=SEGMENT -> parameters updated, IDX/DIV not reset; if IDX>new CYCLE_s, IDX wraps to 0 at next advance.
REQ-017 RUN/FINITE/HALT: UPDATE with REP!=INFINITE_REP and REQ!=SEGMENT -> WAIT, REP latched as loop count.
REQ-018 WAIT: at the wrap event of the current segment (REQ-013 wrap) -> SEGMENT<=REQ, IDX<=0, DIV<=0, LOOP<=0, -> FINITE; IDX_ADV asserted that cycle.
REQ-019 WAIT: new UPDATE replaces pending request; UPDATE with REP=INFINITE_REP applies REQ-015 and -> RUN.
REQ-020 FINITE: each wrap increments LOOP (32b); wrap when LOOP=REP -> HALT, IDX held at CYCLE_s, no IDX_ADV, STOP=1 same cycle.
REQ-021 Segment plays exactly REP+1 full cycles before HALT; REP=0 means one cycle.
REQ-022 HALT: DIV and IDX frozen; only UPDATE leaves HALT (REQ-015 from HALT also -> RUN, STOP<=0).
REQ-023 UPDATE with REP!=INFINITE_REP and REQ=SEGMENT -> parameters updated, IDX/LOOP unchanged, state unchanged.
REQ-024 UPDATE coincident with a divider/wrap event: the event is processed with the old parameters, the UPDATE is applied at that cycle's edge, the new state takes effect next cycle.
REQ-025 LOOP shall not wrap; the comparison is equality only.
REQ-026 All outputs registered; IDX_ADV latency from divider terminal count is zero cycles (same edge as IDX change).

Reset
REQ-027 RESET_N=0 at an edge: SEGMENT=0, IDX=0, IDX_ADV=0, STOP=0, DIV=0, LOOP=0, state RUN, latched settings all zero (cycle 1, div 1).
REQ-028 Reset overrides UPDATE in the same cycle; reset mid-WAIT discards the pending swap.
REQ-029 First IDX_ADV after reset release with no UPDATE occurs every cycle (FREQ_DIV=0 -> 1), IDX stays 0 (CYCLE=0).

Verification
REQ-030 UPDATE{seg0, CYCLE_0=3, FREQ_DIV_0=2, REP=INF} -> IDX 0,0,1,1,2,2,3,3,0..., IDX_ADV every 2nd cycle.
REQ-031 Running seg0 at IDX=2, UPDATE{seg1, REP=INF} -> next cycle SEGMENT=1, IDX=0, DIV=0.
REQ-032 Running seg0 (CYCLE_0=3) at IDX=1, UPDATE{seg1, CYCLE_1=1, REP=1} -> seg0 finishes to 3, swaps at wrap, seg1 plays 0,1,0,1, then HALT with IDX=1, STOP=1.
REQ-033 In HALT, UPDATE{seg0, REP=INF} -> SEGMENT=0, IDX=0, STOP=0, state RUN.
REQ-034 In WAIT, assert RESET_N=0 one cycle -> all outputs at reset values, no swap afterwards.
REQ-035 UPDATE in the exact cycle of a wrap with FREQ_DIV change -> wrap uses old divider, new divider counted from DIV=0 next cycle.
